// File: rtl/request_queue_writer.sv
// ---------------------------------------------------------------------------
// request_queue_writer
//
// Insertion side of a four-slot elevator floor-call queue. Floor-call requests
// arrive over a valid/ready handshake and are appended at the tail of the
// queue. Removal of entries is done by external logic. That logic sees this
// cycle's insertion on next_queue_add and returns the queue after removal on
// next_queue_sub. The registered queue is then loaded from next_queue_sub.
//
// A request that arrives while the queue is full is still accepted. It is
// parked in a single pending register, and the block stalls (req_ready low)
// until a slot frees. The pending level is then inserted.
//
// Optional feature (compile-time macro REQ_QUEUE_DEDUP_EN):
//   When the macro is defined, a candidate level that is already present in
//   the queue is discarded. No insertion is made, and dup_drop pulses high for
//   one cycle. When the macro is undefined, duplicates are enqueued normally
//   and dup_drop is tied low.
//
// Ports
//   clk              in   1  clock, rising edge
//   rst_n            in   1  asynchronous active-low reset
//   req_valid        in   1  floor-call request present
//   req_lvl          in   2  requested level 0..3
//   req_ready        out  1  request accepted this cycle (state ACCEPT)
//   next_queue_sub   in   8  queue after removal (slot k = bits [2k+1:2k])
//   stop_at_pos_lvl  in   1  removal logic removed one entry this cycle
//   next_queue_add   out  8  queue_q plus this cycle's insertion
//   next_tail_add    out  3  tail_q plus this cycle's insertion
//   queue_q          out  8  registered queue, slot 0 is head
//   tail_q           out  3  registered entry count 0..4
//   full             out  1  tail_q == 4
//   dup_drop         out  1  one-cycle pulse after a duplicate is discarded
// ---------------------------------------------------------------------------
module request_queue_writer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_lvl,
  output logic       req_ready,
  input  logic [7:0] next_queue_sub,
  input  logic       stop_at_pos_lvl,
  output logic [7:0] next_queue_add,
  output logic [2:0] next_tail_add,
  output logic [7:0] queue_q,
  output logic [2:0] tail_q,
  output logic       full,
  output logic       dup_drop
);

  localparam int unsigned DEPTH = 4;

  typedef enum logic {
    ACCEPT = 1'b0,
    STALL  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] pend_lvl;

  logic       cand_valid;
  logic [1:0] cand_lvl;
  logic       is_dup;
  logic       do_insert;

  assign req_ready = (state == ACCEPT);
  assign full      = (tail_q == 3'(DEPTH));

  // The insertion candidate is the live request while accepting. While
  // stalled, it is the parked pending level, which is always ready to insert.
  // NOTE: every signal written in always_comb receives a value on all paths
  // (here via the unconditional assignments); otherwise a latch is inferred.
  always_comb begin
    cand_valid = (state == STALL) ? 1'b1 : req_valid;
    cand_lvl   = (state == STALL) ? pend_lvl : req_lvl;
  end

`ifdef REQ_QUEUE_DEDUP_EN
  // Only occupied slots take part in the comparison. Empty slots hold 2'b00,
  // which would otherwise falsely match a level-0 request.
  always_comb begin
    is_dup = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((3'(k) < tail_q) && (queue_q[2*k +: 2] == cand_lvl)) begin
        is_dup = 1'b1;
      end
    end
    is_dup = is_dup & cand_valid;
  end
`else
  assign is_dup = 1'b0;
`endif

  // The duplicate check outranks the full check. A discarded request never
  // reaches the stall path.
  assign do_insert = cand_valid & ~is_dup & ~full;

  // Occupied slots pass through, and the candidate lands at slot tail_q.
  // Every slot beyond the new tail is forced to zero.
  always_comb begin
    next_queue_add = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (3'(k) < tail_q) begin
        next_queue_add[2*k +: 2] = queue_q[2*k +: 2];
      end else if ((3'(k) == tail_q) && do_insert) begin
        next_queue_add[2*k +: 2] = cand_lvl;
      end
    end
    next_tail_add = tail_q + {2'b00, do_insert};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCEPT;
      pend_lvl <= '0;
      queue_q  <= '0;
      tail_q   <= '0;
      dup_drop <= 1'b0;
    end else begin
      queue_q  <= next_queue_sub;
      // A removal request against an empty queue cannot occur with a sane
      // removal block. The guard keeps the count from wrapping if one does.
      tail_q   <= (stop_at_pos_lvl && (next_tail_add != 3'd0))
                  ? next_tail_add - 3'd1 : next_tail_add;
      dup_drop <= is_dup;
      case (state)
        ACCEPT: begin
          if (req_valid && !is_dup && full) begin
            pend_lvl <= req_lvl;
            state    <= STALL;
          end
        end
        STALL: begin
          if (do_insert || is_dup) begin
            state <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule
